// File: rtl/banner_pkg.sv
// -----------------------------------------------------------------------------
// banner_pkg
// Shared constants and types for the text-banner reader.
//   ROM_W    : width of one banner ROM row in pixels (bits)
//   ROM_ROWS : number of valid banner rows (addresses 1..ROM_ROWS)
//   ROM_AW   : ROM row address width (address 0 reads back blank)
//   IDX_W    : width of a column index into a ROM row
// -----------------------------------------------------------------------------
package banner_pkg;

    localparam int ROM_W    = 1440;
    localparam int ROM_ROWS = 41;
    localparam int ROM_AW   = 6;
    localparam int IDX_W    = 11;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [ROM_AW-1:0] addr_t;

endpackage

// File: rtl/banner_mod_add.sv
// -----------------------------------------------------------------------------
// banner_mod_add
// Combinational (a + b) mod ROM_W for operands already below ROM_W.
// The raw sum is below 2*ROM_W, so a single conditional subtract suffices.
// Ports:
//   a, b : operands, each < ROM_W
//   sum  : (a + b) mod ROM_W
// -----------------------------------------------------------------------------
module banner_mod_add
    import banner_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    output logic [IDX_W-1:0] sum
);

    localparam logic [IDX_W:0] WRAP = (IDX_W+1)'(ROM_W);

    logic [IDX_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = (raw >= WRAP) ? idx_t'(raw - WRAP) : raw[IDX_W-1:0];
    end

endmodule

// File: rtl/banner_scanner.sv
// -----------------------------------------------------------------------------
// banner_scanner
// Reader side of the banner ROM. Generates the ROM row address one line ahead
// of the raster, latches the row at line_end, and produces a per-pixel
// "text on" flag two cycles after the pixel coordinates, with a per-frame
// horizontal marquee scroll.
//
// Ports:
//   clk, rst        : pixel clock, asynchronous active-high reset
//   pix_x, pix_y    : raster coordinates from the timing generator
//   de              : active-video enable
//   line_end        : pulse after the last active pixel; loads the row buffer
//   frame_end       : pulse after the last active line; advances scroll
//   scroll_en       : enables scroll advance at frame_end
//   rom_addr        : registered row address to the external banner ROM
//   rom_data        : row bits from the ROM, MSB is the leftmost pixel
//   pix_on, pix_de  : banner foreground and de, both 2 cycles after input
//
// Build option:
//   BANNER_BLINK_EN : when defined, the banner blinks with a half-period of
//                     BLINK_FRAMES frames; otherwise it is always visible.
// -----------------------------------------------------------------------------
module banner_scanner
    import banner_pkg::*;
#(
    parameter int X0           = 200,
    parameter int Y0           = 100,
    parameter int WIN_W        = 640,
    parameter int SCROLL_STEP  = 2,
    parameter int BLINK_FRAMES = 30
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic              de,
    input  logic              line_end,
    input  logic              frame_end,
    input  logic              scroll_en,
    output logic [5:0]        rom_addr,
    input  logic [1439:0]     rom_data,
    output logic              pix_on,
    output logic              pix_de
);

    localparam logic [11:0] X_LO    = 12'(X0);
    localparam logic [11:0] X_HI    = 12'(X0 + WIN_W);
    localparam logic [11:0] Y_LO    = 12'(Y0);
    localparam logic [11:0] Y_HI    = 12'(Y0 + ROM_ROWS);
    localparam idx_t        STEP    = idx_t'(SCROLL_STEP);
    localparam idx_t        IDX_MAX = idx_t'(ROM_W - 1);

    logic [ROM_W-1:0] row_buf;
    idx_t             scroll;
    idx_t             scroll_nxt;
    idx_t             col_off;
    idx_t             idx_nxt;
    idx_t             idx1;
    logic             win1;
    logic             de1;
    logic             visible;
    logic [11:0]      x_ext;
    logic [11:0]      y_ext;
    logic [11:0]      ny;
    logic             in_x;
    logic             in_y;
    addr_t            addr_nxt;

    always_comb begin
        x_ext    = {1'b0, pix_x};
        y_ext    = {1'b0, pix_y};
        ny       = y_ext + 12'd1;
        in_x     = (x_ext >= X_LO) && (x_ext < X_HI);
        in_y     = (y_ext >= Y_LO) && (y_ext < Y_HI);
        // Out-of-window columns feed a safe zero so the row index stays in range.
        col_off  = in_x ? idx_t'(x_ext - X_LO) : '0;
        // Address for the line about to start, so the row is ready at line_end.
        addr_nxt = '0;
        if ((ny >= Y_LO) && (ny < Y_HI)) begin
            addr_nxt = addr_t'(ny - Y_LO + 12'd1);
        end
    end

    banner_mod_add u_idx_add (
        .a   (col_off),
        .b   (scroll),
        .sum (idx_nxt)
    );

    banner_mod_add u_scroll_add (
        .a   (scroll),
        .b   (STEP),
        .sum (scroll_nxt)
    );

`ifdef BANNER_BLINK_EN
    localparam int BLINK_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_CW-1:0] blink_cnt;
    logic                blink_vis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + BLINK_CW'(1);
            end
        end
    end

    assign visible = blink_vis;
`else
    assign visible = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            row_buf  <= '0;
            scroll   <= '0;
            win1     <= 1'b0;
            idx1     <= '0;
            de1      <= 1'b0;
            pix_on   <= 1'b0;
            pix_de   <= 1'b0;
        end else begin
            rom_addr <= addr_nxt;
            if (line_end) begin
                row_buf <= rom_data;
            end
            if (frame_end && scroll_en) begin
                scroll <= scroll_nxt;
            end
            win1   <= de & in_x & in_y;
            idx1   <= idx_nxt;
            de1    <= de;
            // Reads row_buf before any same-edge load, so the old row finishes.
            pix_on <= de1 & win1 & row_buf[IDX_MAX - idx1] & visible;
            pix_de <= de1;
        end
    end

endmodule

// File: tb/tb_banner_scanner.sv
// -----------------------------------------------------------------------------
// tb_banner_scanner
// Randomized and directed stimulus for banner_scanner, checked against a
// screen-level model: a pixel (x, y) is lit when it lies in the banner window
// and bit (1439 - ((x - X0 + scroll) mod 1440)) of ROM row (y - Y0 + 1) is set.
// -----------------------------------------------------------------------------
module tb_banner_scanner;

    localparam int X0    = 200;
    localparam int Y0    = 100;
    localparam int WIN_W = 640;
    localparam int STEP  = 2;
    localparam int BLINK = 30;
    localparam int W     = 1440;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   pix_x;
    logic [10:0]   pix_y;
    logic          de;
    logic          line_end;
    logic          frame_end;
    logic          scroll_en;
    logic [5:0]    rom_addr;
    logic [1439:0] rom_data;
    logic          pix_on;
    logic          pix_de;

    logic [1439:0] rom_mem [0:63];

    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    banner_scanner #(
        .X0           (X0),
        .Y0           (Y0),
        .WIN_W        (WIN_W),
        .SCROLL_STEP  (STEP),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .de        (de),
        .line_end  (line_end),
        .frame_end (frame_end),
        .scroll_en (scroll_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_on    (pix_on),
        .pix_de    (pix_de)
    );

    int            n_vec = 0;
    int            n_err = 0;

    // model state
    int            m_scroll;
    logic [1439:0] m_row;
    int            m_blink_cnt;
    bit            m_vis;
    bit            q_on[$];
    bit            q_de[$];
    int            px_q[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1439:0] rom_row(input int line);
        int r;
        r = line - Y0 + 1;
        if (r >= 1 && r <= 41) return rom_mem[r];
        return '0;
    endfunction

    task automatic model_reset();
        m_scroll    = 0;
        m_row       = '0;
        m_blink_cnt = 0;
        m_vis       = 1'b1;
        q_on.delete();
        q_de.delete();
    endtask

    // Applies one cycle of inputs (called just after a rising edge), then
    // checks outputs one time unit after the next rising edge.
    task automatic step(input bit d, input int x, input int y,
                        input bit le, input bit fe, input bit se);
        bit win;
        int idx;
        int nyv;
        int exp_addr;
        de        = d;
        pix_x     = 11'(x);
        pix_y     = 11'(y);
        line_end  = le;
        frame_end = fe;
        scroll_en = se;

        win = d && (x >= X0) && (x < X0 + WIN_W) && (y >= Y0) && (y < Y0 + 41);
        idx = win ? (x - X0 + m_scroll) % W : 0;
        q_on.push_back(win && m_row[W - 1 - idx] && m_vis);
        q_de.push_back(d);

        nyv      = y + 1;
        exp_addr = (nyv >= Y0 && nyv < Y0 + 41) ? nyv - Y0 + 1 : 0;

        if (le) m_row = rom_row(y + 1);
        if (fe) begin
            if (se) m_scroll = (m_scroll + STEP) % W;
`ifdef BANNER_BLINK_EN
            m_blink_cnt++;
            if (m_blink_cnt == BLINK) begin
                m_blink_cnt = 0;
                m_vis       = !m_vis;
            end
`endif
        end

        @(posedge clk);
        #1;
        check_val("rom_addr", int'(rom_addr), exp_addr);
        if (q_on.size() == 2) begin
            check_val("pix_on", int'(pix_on), int'(q_on.pop_front()));
            check_val("pix_de", int'(pix_de), int'(q_de.pop_front()));
        end
    endtask

    // Ends line y-1 with line_end (loading the row for y), then scans px_q on line y.
    task automatic scan_line(input int y);
        step(0, 0, y - 1, 0, 0, 0);
        step(0, 0, y - 1, 1, 0, 0);
        foreach (px_q[i]) step(1, px_q[i], y, 0, 0, 0);
        px_q.delete();
    endtask

    task automatic random_line(input int y, input int n);
        step(0, 0, y - 1, 0, 0, 0);
        step(0, 0, y - 1, 1, 0, 0);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(X0 - 12, X0 + WIN_W + 12),
                 y, 0, 0, 0);
        end
    endtask

    task automatic frame_pulses(input int n, input bit se);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, se);
    endtask

    initial begin
        for (int r = 0; r < 64; r++) begin
            rom_mem[r] = '0;
            if (r >= 1 && r <= 41) begin
                for (int k = 0; k < 45; k++) rom_mem[r][k*32 +: 32] = $urandom();
            end
        end
        rom_mem[1][1427]       = 1'b1;
        rom_mem[1][1428]       = 1'b0;
        rom_mem[1][1434]       = 1'b0;
        rom_mem[26][1437:1436] = 2'b11;
        rom_mem[26][1439:1438] = 2'b00;

        // reset asserted with an active in-window pixel: outputs must be low
        rst       = 1'b1;
        de        = 1'b1;
        pix_x     = 11'd300;
        pix_y     = 11'd120;
        line_end  = 1'b0;
        frame_end = 1'b0;
        scroll_en = 1'b0;
        #3;
        check_val("reset_pix_on", int'(pix_on), 0);
        check_val("reset_pix_de", int'(pix_de), 0);
        check_val("reset_rom_addr", int'(rom_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // row/column mapping at scroll 0
        px_q = '{212, 211, 200, 199, 839, 840, 212};
        scan_line(100);
        px_q = '{202, 203, 200, 201, 202};
        scan_line(125);
        px_q = '{250, 500, 212};
        scan_line(99);
        px_q = '{300, 212, 839};
        scan_line(141);
        px_q = '{300, 200, 839, 840};
        scan_line(140);

        // scroll wrap: 1438 -> 0, then 1430
        frame_pulses(719, 1'b1);
        frame_pulses(3, 1'b0);
        px_q = '{212, 200, 201};
        scan_line(100);
        frame_pulses(1, 1'b1);
        px_q = '{212, 211};
        scan_line(100);
        frame_pulses(715, 1'b1);
        px_q = '{215, 210, 209, 839};
        scan_line(100);

        // randomized lines and frames
        for (int i = 0; i < 300; i++) begin
            random_line($urandom_range(95, 145), $urandom_range(4, 16));
            if ($urandom_range(0, 3) == 0) frame_pulses(1, $urandom_range(0, 1) == 1);
        end

        // mid-line reset: rest of the line is blank
        random_line(120, 6);
        de    = 1'b1;
        pix_x = 11'd400;
        pix_y = 11'd120;
        #2 rst = 1'b1;
        #1;
        check_val("midrst_pix_on", int'(pix_on), 0);
        check_val("midrst_pix_de", int'(pix_de), 0);
        check_val("midrst_rom_addr", int'(rom_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) step(1, $urandom_range(X0, X0 + WIN_W - 1), 120, 0, 0, 0);
        random_line(10, 4);
        for (int i = 0; i < 20; i++) random_line($urandom_range(98, 142), 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
